// File: rtl/saturn_bus_pkg.sv
// Shared constants for the Saturn nibble-bus master: bus command codes,
// request op encoding, FSM state enum and the "no mode yet" marker.
package saturn_bus_pkg;

    localparam logic [3:0] CMD_PC_READ  = 4'h0;
    localparam logic [3:0] CMD_DP_READ  = 4'h1;
    localparam logic [3:0] CMD_DP_WRITE = 4'h3;
    localparam logic [3:0] CMD_LOAD_PC  = 4'h4;
    localparam logic [3:0] CMD_LOAD_DP  = 4'h5;
    localparam logic [3:0] MODE_NONE    = 4'hF;

    localparam logic [1:0] OP_PC_READ  = 2'b00;
    localparam logic [1:0] OP_DP_READ  = 2'b01;
    localparam logic [1:0] OP_RESERVED = 2'b10;
    localparam logic [1:0] OP_DP_WRITE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_CMD = 3'd1,
        ST_ADDR     = 3'd2,
        ST_MODE_CMD = 3'd3,
        ST_XFER     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    function automatic logic [3:0] op_cmd(input logic [1:0] op);
        case (op)
            OP_PC_READ:  op_cmd = CMD_PC_READ;
            OP_DP_READ:  op_cmd = CMD_DP_READ;
            OP_DP_WRITE: op_cmd = CMD_DP_WRITE;
            default:     op_cmd = MODE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/saturn_bus_ptr.sv
// Bus-side pointer shadow: load from an address, increment with natural
// wrap, and a valid bit that says the shadow matches the bus device.
module saturn_bus_ptr #(
    parameter int W = 20
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr,
    output logic         o_valid
);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ptr   <= '0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_ptr   <= i_load_val;
            o_valid <= 1'b1;
        end else if (i_inc) begin
            o_ptr <= o_ptr + W'(1);
        end
    end

endmodule

// File: rtl/saturn_bus_master.sv
// Saturn nibble-bus master serving PC/DP reads and DP writes in bursts.
// Optional pointer cache: define SATURN_BUS_PTR_CACHE_EN to skip redundant pointer loads.
module saturn_bus_master
    import saturn_bus_pkg::*;
#(
    parameter int ADDR_NIBBLES = 5,
    parameter int LEN_W        = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req,
    input  logic [1:0]                i_op,
    input  logic [4*ADDR_NIBBLES-1:0] i_addr,
    input  logic [LEN_W-1:0]          i_len,
    input  logic [3:0]                i_wr_nibble,
    output logic                      o_ack,
    output logic                      o_busy,
    output logic                      o_wr_pop,
    output logic [3:0]                o_rd_nibble,
    output logic                      o_rd_valid,
    output logic                      o_done,
    output logic [4*ADDR_NIBBLES-1:0] o_pc,
    output logic [4*ADDR_NIBBLES-1:0] o_dp,
    input  logic [3:0]                i_bus_data,
    output logic [3:0]                o_bus_data,
    output logic                      o_bus_strobe,
    output logic                      o_bus_cmd_data,
    output state_t                    o_state,
    output logic [1:0]                o_ptr_valid
);

    localparam int AW     = 4 * ADDR_NIBBLES;
    localparam int AIDX_W = $clog2(ADDR_NIBBLES + 1);

    // Handshake: the requester holds i_req with stable op/addr/len until the
    // one-cycle o_ack; write data must sit on i_wr_nibble during each o_wr_pop cycle.
    state_t              state, state_d;
    logic [1:0]          op_q, op_d;
    logic [AW-1:0]       addr_q, addr_d, addr_sh, addr_sh_d;
    logic [LEN_W-1:0]    len_q, len_d, cnt, cnt_d;
    logic [AIDX_W-1:0]   acnt, acnt_d;
    logic [3:0]          bus_mode, mode_d, load_mode;
    logic                rd_strobe_q, rd_strobe_d;
    logic                ack_d, strobe_d, cd_d, wr_pop_d, done_d;
    logic [3:0]          bus_data_d;
    logic                pc_load, dp_load, pc_inc, dp_inc;
    logic                pc_valid, dp_valid, pc_hit, dp_hit, hit;
    logic                is_pc, is_wr;

    saturn_bus_ptr #(.W(AW)) u_pc (
        .i_clk(i_clk), .i_reset(i_reset), .i_load(pc_load), .i_load_val(addr_q),
        .i_inc(pc_inc), .o_ptr(o_pc), .o_valid(pc_valid)
    );

    saturn_bus_ptr #(.W(AW)) u_dp (
        .i_clk(i_clk), .i_reset(i_reset), .i_load(dp_load), .i_load_val(addr_q),
        .i_inc(dp_inc), .o_ptr(o_dp), .o_valid(dp_valid)
    );

`ifdef SATURN_BUS_PTR_CACHE_EN
    assign pc_hit = pc_valid && (o_pc == i_addr);
    assign dp_hit = dp_valid && (o_dp == i_addr);
`else
    assign pc_hit = 1'b0;
    assign dp_hit = 1'b0;
`endif

    assign hit         = (i_op == OP_PC_READ) ? pc_hit : dp_hit;
    assign is_pc       = (op_q == OP_PC_READ);
    assign is_wr       = (op_q == OP_DP_WRITE);
    assign o_state     = state;
    assign o_ptr_valid = {dp_valid, pc_valid};

    always_comb begin
        state_d     = state;
        op_d        = op_q;
        addr_d      = addr_q;
        addr_sh_d   = addr_sh;
        len_d       = len_q;
        cnt_d       = cnt;
        acnt_d      = acnt;
        mode_d      = bus_mode;
        load_mode   = bus_mode;
        ack_d       = 1'b0;
        strobe_d    = 1'b0;
        cd_d        = 1'b1;
        bus_data_d  = 4'h0;
        rd_strobe_d = 1'b0;
        done_d      = 1'b0;
        pc_load     = 1'b0;
        dp_load     = 1'b0;
        pc_inc      = 1'b0;
        dp_inc      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req) begin
                    op_d      = i_op;
                    addr_d    = i_addr;
                    addr_sh_d = i_addr;
                    len_d     = i_len;
                    cnt_d     = '0;
                    acnt_d    = '0;
                    ack_d     = 1'b1;
                    if (i_op == OP_RESERVED)            state_d = ST_DONE;
                    else if (!hit)                      state_d = ST_LOAD_CMD;
                    else if (bus_mode != op_cmd(i_op))  state_d = ST_MODE_CMD;
                    else                                state_d = ST_XFER;
                end
            end
            ST_LOAD_CMD: begin
                strobe_d   = 1'b1;
                cd_d       = 1'b0;
                bus_data_d = is_pc ? CMD_LOAD_PC : CMD_LOAD_DP;
                state_d    = ST_ADDR;
            end
            ST_ADDR: begin
                strobe_d   = 1'b1;
                bus_data_d = addr_sh[3:0];
                addr_sh_d  = addr_sh >> 4;
                acnt_d     = acnt + AIDX_W'(1);
                if (acnt == AIDX_W'(ADDR_NIBBLES - 1)) begin
                    // A pointer load leaves the device in the matching read mode.
                    pc_load   = is_pc;
                    dp_load   = !is_pc;
                    load_mode = is_pc ? CMD_PC_READ : CMD_DP_READ;
                    mode_d    = load_mode;
                    state_d   = (load_mode != op_cmd(op_q)) ? ST_MODE_CMD : ST_XFER;
                end
            end
            ST_MODE_CMD: begin
                strobe_d   = 1'b1;
                cd_d       = 1'b0;
                bus_data_d = op_cmd(op_q);
                mode_d     = op_cmd(op_q);
                state_d    = ST_XFER;
            end
            ST_XFER: begin
                strobe_d    = 1'b1;
                bus_data_d  = is_wr ? i_wr_nibble : 4'h0;
                rd_strobe_d = !is_wr;
                pc_inc      = is_pc;
                dp_inc      = !is_pc;
                cnt_d       = cnt + LEN_W'(1);
                if (cnt == len_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Pop one cycle ahead so the nibble is captured as it goes onto the bus.
        wr_pop_d = (state_d == ST_XFER) && (op_d == OP_DP_WRITE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            op_q           <= OP_PC_READ;
            addr_q         <= '0;
            addr_sh        <= '0;
            len_q          <= '0;
            cnt            <= '0;
            acnt           <= '0;
            bus_mode       <= MODE_NONE;
            rd_strobe_q    <= 1'b0;
            o_ack          <= 1'b0;
            o_busy         <= 1'b0;
            o_wr_pop       <= 1'b0;
            o_rd_nibble    <= 4'h0;
            o_rd_valid     <= 1'b0;
            o_done         <= 1'b0;
            o_bus_data     <= 4'h0;
            o_bus_strobe   <= 1'b0;
            o_bus_cmd_data <= 1'b1;
        end else begin
            state          <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            addr_sh        <= addr_sh_d;
            len_q          <= len_d;
            cnt            <= cnt_d;
            acnt           <= acnt_d;
            bus_mode       <= mode_d;
            rd_strobe_q    <= rd_strobe_d;
            o_ack          <= ack_d;
            o_busy         <= (state_d != ST_IDLE);
            o_wr_pop       <= wr_pop_d;
            o_rd_valid     <= rd_strobe_q;
            if (rd_strobe_q) o_rd_nibble <= i_bus_data;
            o_done         <= done_d;
            o_bus_data     <= bus_data_d;
            o_bus_strobe   <= strobe_d;
            o_bus_cmd_data <= cd_d;
        end
    end

endmodule

// File: tb/tb_saturn_bus_master.sv
// Directed bench for saturn_bus_master: bus-nibble and read-data scoreboards,
// latency and pointer checks, mid-transfer reset and the reserved op.
module tb_saturn_bus_master;
    import saturn_bus_pkg::*;

    localparam int AN = 5;
    localparam int LW = 4;
    localparam int AW = 4 * AN;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_req = 1'b0;
    logic [1:0]    i_op = 2'b00;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_len = '0;
    logic [3:0]    i_wr_nibble = 4'h0;
    logic [3:0]    i_bus_data = 4'h0;
    logic          o_ack, o_busy, o_wr_pop, o_rd_valid, o_done;
    logic [3:0]    o_rd_nibble, o_bus_data;
    logic [AW-1:0] o_pc, o_dp;
    logic          o_bus_strobe, o_bus_cmd_data;
    state_t        o_state;
    logic [1:0]    o_ptr_valid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pop_cnt = 0;
    logic [4:0] exp_q[$];
    logic [3:0] rd_exp_q[$];
    logic [3:0] wr_q[$];

    saturn_bus_master #(.ADDR_NIBBLES(AN), .LEN_W(LW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_op(i_op),
        .i_addr(i_addr), .i_len(i_len), .i_wr_nibble(i_wr_nibble),
        .o_ack(o_ack), .o_busy(o_busy), .o_wr_pop(o_wr_pop),
        .o_rd_nibble(o_rd_nibble), .o_rd_valid(o_rd_valid), .o_done(o_done),
        .o_pc(o_pc), .o_dp(o_dp), .i_bus_data(i_bus_data), .o_bus_data(o_bus_data),
        .o_bus_strobe(o_bus_strobe), .o_bus_cmd_data(o_bus_cmd_data),
        .o_state(o_state), .o_ptr_valid(o_ptr_valid)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_load(input logic [3:0] cmd, input logic [AW-1:0] addr);
        exp_q.push_back({1'b0, cmd});
        for (int i = 0; i < AN; i++) exp_q.push_back({1'b1, addr[4*i +: 4]});
    endtask

    // Scoreboard monitor: every strobe and every read nibble is popped and compared.
    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_bus_strobe) begin
                if (exp_q.size() == 0) check("bus_extra_strobe", {27'd0, o_bus_cmd_data, o_bus_data}, 32'h100);
                else check("bus_nibble", {27'd0, o_bus_cmd_data, o_bus_data}, {27'd0, exp_q.pop_front()});
            end
            if (o_rd_valid) begin
                if (rd_exp_q.size() == 0) check("rd_extra", {28'd0, o_rd_nibble}, 32'h100);
                else check("rd_nibble", {28'd0, o_rd_nibble}, {28'd0, rd_exp_q.pop_front()});
            end
            if (o_wr_pop) begin
                i_wr_nibble = (wr_q.size() != 0) ? wr_q.pop_front() : 4'h0;
                pop_cnt++;
            end
        end
    end

    // Driver: issue one request, wait (bounded) for ack and done, check latency.
    task automatic run_req(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input int exp_lat, input string tag);
        int t;
        int ack_c;
        i_op = op; i_addr = addr; i_len = len; i_req = 1'b1;
        t = 0;
        while (!o_ack && t < 20) begin @(negedge clk); t++; end
        check({tag, "_ack"}, {31'd0, o_ack}, 32'd1);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
        ack_c = cyc;
        i_req = 1'b0;
        t = 0;
        while (!o_done && t < 60) begin @(negedge clk); t++; end
        check({tag, "_done"}, {31'd0, o_done}, 32'd1);
        check({tag, "_latency"}, cyc - ack_c, exp_lat);
        @(negedge clk);
        check({tag, "_bus_left"}, exp_q.size(), 32'd0);
        check({tag, "_rd_left"}, rd_exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [3:0] r;
        int done_seen;

        repeat (3) @(negedge clk);
        check("rst_strobe", {31'd0, o_bus_strobe}, 32'd0);
        check("rst_cmd_data", {31'd0, o_bus_cmd_data}, 32'd1);
        check("rst_bus_data", {28'd0, o_bus_data}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_pulses", {29'd0, o_ack, o_done, o_rd_valid}, 32'd0);
        check("rst_pc", o_pc, 32'd0);
        check("rst_dp", o_dp, 32'd0);
        check("rst_state", {29'd0, o_state}, {29'd0, ST_IDLE});
        i_reset = 1'b0;
        @(negedge clk);

        // PC read with load, len 0
        i_bus_data = 4'hA;
        push_load(CMD_LOAD_PC, 20'h00123);
        exp_q.push_back({1'b1, 4'h0});
        rd_exp_q.push_back(4'hA);
        run_req(OP_PC_READ, 20'h00123, 4'd0, 8, "pc_read");
        check("pc_read_pc", o_pc, 32'h00124);

        // DP write, len 3: load, address, mode command, four data nibbles
        wr_q = '{4'h1, 4'h2, 4'h3, 4'h4};
        pop_cnt = 0;
        push_load(CMD_LOAD_DP, 20'h8F000);
        exp_q.push_back({1'b0, CMD_DP_WRITE});
        for (int i = 1; i <= 4; i++) exp_q.push_back({1'b1, 4'(i)});
        run_req(OP_DP_WRITE, 20'h8F000, 4'd3, 12, "dp_write");
        check("dp_write_pops", pop_cnt, 32'd4);
        check("dp_write_dp", o_dp, 32'h8F004);

        // Consecutive PC reads: the second one hits the pointer when caching
        r = 4'($urandom_range(0, 15));
        i_bus_data = r;
        push_load(CMD_LOAD_PC, 20'h00200);
        exp_q.push_back({1'b1, 4'h0});
        exp_q.push_back({1'b1, 4'h0});
        rd_exp_q.push_back(r);
        rd_exp_q.push_back(r);
        run_req(OP_PC_READ, 20'h00200, 4'd1, 9, "pc_burst");
        check("pc_burst_pc", o_pc, 32'h00202);
        r = 4'($urandom_range(0, 15));
        i_bus_data = r;
`ifdef SATURN_BUS_PTR_CACHE_EN
        exp_q.push_back({1'b1, 4'h0});
        rd_exp_q.push_back(r);
        run_req(OP_PC_READ, 20'h00202, 4'd0, 2, "pc_cached");
`else
        push_load(CMD_LOAD_PC, 20'h00202);
        exp_q.push_back({1'b1, 4'h0});
        rd_exp_q.push_back(r);
        run_req(OP_PC_READ, 20'h00202, 4'd0, 8, "pc_cached");
`endif
        check("pc_cached_pc", o_pc, 32'h00203);

        // DP read across the top of the address space
        r = 4'($urandom_range(0, 15));
        i_bus_data = r;
        push_load(CMD_LOAD_DP, 20'hFFFFF);
        exp_q.push_back({1'b1, 4'h0});
        exp_q.push_back({1'b1, 4'h0});
        rd_exp_q.push_back(r);
        rd_exp_q.push_back(r);
        run_req(OP_DP_READ, 20'hFFFFF, 4'd1, 9, "dp_wrap");
        check("dp_wrap_dp", o_dp, 32'h00001);

        // Reserved op: ack, done one cycle later, no strobes
        run_req(OP_RESERVED, 20'h12345, 4'd2, 1, "reserved");
        check("reserved_dp", o_dp, 32'h00001);

        // Reset during the third address nibble
        exp_q.push_back({1'b0, CMD_LOAD_PC});
        exp_q.push_back({1'b1, 4'h3});
        exp_q.push_back({1'b1, 4'h2});
        exp_q.push_back({1'b1, 4'h1});
        i_op = OP_PC_READ; i_addr = 20'h00123; i_len = 4'd0; i_req = 1'b1;
        @(negedge clk);
        check("mid_rst_ack", {31'd0, o_ack}, 32'd1);
        i_req = 1'b0;
        repeat (4) @(negedge clk);
        #1 i_reset = 1'b1;
        @(negedge clk);
        check("mid_rst_strobe", {31'd0, o_bus_strobe}, 32'd0);
        check("mid_rst_cmd_data", {31'd0, o_bus_cmd_data}, 32'd1);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_pc", o_pc, 32'd0);
        check("mid_rst_valid", {30'd0, o_ptr_valid}, 32'd0);
        check("mid_rst_bus_left", exp_q.size(), 32'd0);
        i_reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_done) done_seen++;
        end
        check("mid_rst_no_done", done_seen, 32'd0);

        // After reset the same request must reload the pointer
        i_bus_data = 4'h6;
        push_load(CMD_LOAD_PC, 20'h00123);
        exp_q.push_back({1'b1, 4'h0});
        rd_exp_q.push_back(4'h6);
        run_req(OP_PC_READ, 20'h00123, 4'd0, 8, "post_rst");
        check("post_rst_pc", o_pc, 32'h00124);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
